// File: rtl/mvau_stream_pkg.sv
// Shared types and helpers for the MVAU streaming output path.
// Optional out_last marker is enabled by defining MVAU_OUT_LAST_EN.
package mvau_stream_pkg;

  localparam int PE_DEFAULT    = 2;
  localparam int TDSTI_DEFAULT = 16;

  function automatic int out_width(input int pe, input int tdsti);
    return pe * tdsti;
  endfunction

  localparam int OUT_W_DEFAULT = out_width(PE_DEFAULT, TDSTI_DEFAULT);

  typedef logic [OUT_W_DEFAULT-1:0] out_word_t;

  // Counter width that never collapses to zero bits when n is 1.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mvau_sync_fifo.sv
// Synchronous FIFO with occupancy counter; caller guarantees no push when
// full (unless popping) and no pop when empty.
module mvau_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  // Drive zero while empty so the output bus is quiet after reset.
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/mvau_stream_output_block.sv
// MVAU output stage: buffers PE accumulator vectors and streams them out.
// Define MVAU_OUT_LAST_EN to add the out_last end-of-input-vector marker.
module mvau_stream_output_block
  import mvau_stream_pkg::*;
#(
  parameter int PE    = 2,
  parameter int TDstI = 16,
  parameter int NF    = 4,
  parameter int DEPTH = 4,
  parameter int OUT_W = out_width(PE, TDstI)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc_v,
  input  logic [OUT_W-1:0] acc_data,
  input  logic             out_rdy,
  output logic             out_v,
  output logic [OUT_W-1:0] out_data,
  output logic             stall,
  output logic             ovf_err
`ifdef MVAU_OUT_LAST_EN
  ,
  output logic             out_last
`endif
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int NFW = clog2_min1(NF);
  localparam logic [CW-1:0]  NEAR_FULL = CW'(DEPTH - 1);
  localparam logic [NFW-1:0] NF_LAST   = NFW'(NF - 1);

  logic          push, pop, full, empty;
  logic [CW-1:0] count;
  logic          ovf_err_q, ovf_err_d;
  logic [NFW-1:0] nf_cnt_q, nf_cnt_d;

  // Handshake: a beat transfers on a cycle where out_v and out_rdy are both 1;
  // out_v never depends on out_rdy, and out_data is held while out_v & !out_rdy.
  assign pop  = out_v & out_rdy;
  assign push = acc_v & (~full | pop);

  mvau_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (acc_data),
    .dout  (out_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign out_v = ~empty;
  // One slot stays free for an accumulation that is already finishing.
  assign stall   = (count >= NEAR_FULL);
  assign ovf_err = ovf_err_q;

  always_comb begin
    ovf_err_d = ovf_err_q | (acc_v & full & ~pop);
    nf_cnt_d  = nf_cnt_q;
    if (pop) begin
      nf_cnt_d = (nf_cnt_q == NF_LAST) ? '0 : nf_cnt_q + NFW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_err_q <= 1'b0;
      nf_cnt_q  <= '0;
    end else begin
      ovf_err_q <= ovf_err_d;
      nf_cnt_q  <= nf_cnt_d;
      if (!pop) begin
        assert (nf_cnt_d == nf_cnt_q);
      end
    end
  end

`ifdef MVAU_OUT_LAST_EN
  assign out_last = out_v & (nf_cnt_q == NF_LAST);
`endif

endmodule

// File: tb/tb_mvau_stream_output_block.sv
// Directed bench for mvau_stream_output_block (PE=2, TDstI=16, NF=4, DEPTH=4).
module tb_mvau_stream_output_block;
  import mvau_stream_pkg::*;

  localparam int W = out_width(2, 16);

  logic         clk = 1'b0;
  logic         rst_n, acc_v, out_rdy;
  logic [W-1:0] acc_data;
  logic         out_v, stall, ovf_err;
  logic [W-1:0] out_data;
`ifdef MVAU_OUT_LAST_EN
  logic         out_last;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  mvau_stream_output_block #(
    .PE    (2),
    .TDstI (16),
    .NF    (4),
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .acc_v    (acc_v),
    .acc_data (acc_data),
    .out_rdy  (out_rdy),
    .out_v    (out_v),
    .out_data (out_data),
    .stall    (stall),
    .ovf_err  (ovf_err)
`ifdef MVAU_OUT_LAST_EN
    ,
    .out_last (out_last)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] d);
    acc_v    = 1'b1;
    acc_data = d;
    tick();
    acc_v    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; acc_v = 1'b0; out_rdy = 1'b0; acc_data = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({out_v, stall, ovf_err} !== 3'b000 || out_data !== '0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: v/stall/ovf=%b data=%h exp 000 data=0", i,
                 {out_v, stall, ovf_err}, out_data);
      end
    end
  endtask

  task automatic test_single_push();
    out_rdy = 1'b1;
    push_word(32'h0003_0005);
    n_checks++;
    if (out_v !== 1'b1 || out_data !== 32'h0003_0005) begin
      n_fail++;
      $display("FAIL single_out: v=%b data=%h exp v=1 data=00030005", out_v, out_data);
    end
    tick();
    n_checks++;
    if (out_v !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: v=%b exp 0", out_v);
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] exp_stall;
    exp_stall = 3'b100;
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_word(W'(i + 1));
      exp_q.push_back(W'(i + 1));
      n_checks++;
      if (stall !== exp_stall[i] || out_v !== 1'b1 || out_data !== W'(1)) begin
        n_fail++;
        $display("FAIL bp_fill[%0d]: stall=%b v=%b data=%h exp stall=%b v=1 data=1",
                 i, stall, out_v, out_data, exp_stall[i]);
      end
    end
    tick();
    n_checks++;
    if (stall !== 1'b1 || out_data !== W'(1)) begin
      n_fail++;
      $display("FAIL bp_hold: stall=%b data=%h exp stall=1 data=1", stall, out_data);
    end
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_v !== 1'b1 || out_data !== exp_q[0] || stall !== (i == 0)) begin
        n_fail++;
        $display("FAIL bp_drain[%0d]: v=%b data=%h stall=%b exp v=1 data=%h stall=%b",
                 i, out_v, out_data, stall, exp_q[0], (i == 0));
      end
      void'(exp_q.pop_front());
      tick();
    end
    n_checks++;
    if (out_v !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: v=%b stall=%b exp 0 0", out_v, stall);
    end
  endtask

  task automatic test_full_simultaneous();
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_word(W'(32'h10 + i));
      exp_q.push_back(W'(32'h10 + i));
    end
    n_checks++;
    if (stall !== 1'b1 || out_data !== W'(32'h10)) begin
      n_fail++;
      $display("FAIL full_fill: stall=%b data=%h exp stall=1 data=10", stall, out_data);
    end
    out_rdy = 1'b1;
    push_word(W'(5));
    void'(exp_q.pop_front());
    exp_q.push_back(W'(5));
    n_checks++;
    if (ovf_err !== 1'b0 || stall !== 1'b1 || out_data !== W'(32'h11)) begin
      n_fail++;
      $display("FAIL full_simul: ovf=%b stall=%b data=%h exp ovf=0 stall=1 data=11",
               ovf_err, stall, out_data);
    end
    // Four entries still queued proves count stayed at DEPTH.
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_v !== 1'b1 || out_data !== exp_q[0]) begin
        n_fail++;
        $display("FAIL full_drain[%0d]: v=%b data=%h exp v=1 data=%h", i, out_v, out_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      tick();
    end
    n_checks++;
    if (out_v !== 1'b0) begin
      n_fail++;
      $display("FAIL full_empty: v=%b exp 0", out_v);
    end
  endtask

  task automatic test_overflow();
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_word(W'(32'h20 + i));
      exp_q.push_back(W'(32'h20 + i));
    end
    n_checks++;
    if (ovf_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_pre: ovf=%b exp 0", ovf_err);
    end
    push_word(W'(9));
    n_checks++;
    if (ovf_err !== 1'b1 || stall !== 1'b1 || out_data !== W'(32'h20)) begin
      n_fail++;
      $display("FAIL ovf_set: ovf=%b stall=%b data=%h exp ovf=1 stall=1 data=20",
               ovf_err, stall, out_data);
    end
    repeat (2) tick();
    n_checks++;
    if (ovf_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: ovf=%b exp 1", ovf_err);
    end
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_v !== 1'b1 || out_data !== exp_q[0]) begin
        n_fail++;
        $display("FAIL ovf_drain[%0d]: v=%b data=%h exp v=1 data=%h", i, out_v, out_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      tick();
    end
    n_checks++;
    if (out_v !== 1'b0 || ovf_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_end: v=%b ovf=%b exp v=0 ovf=1", out_v, ovf_err);
    end
  endtask

  task automatic test_reset_mid();
    out_rdy = 1'b0;
    push_word(W'(32'h31));
    push_word(W'(32'h32));
    n_checks++;
    if (out_v !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: v=%b exp 1", out_v);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({out_v, stall, ovf_err} !== 3'b000 || out_data !== '0) begin
      n_fail++;
      $display("FAIL rstmid_clear: v/stall/ovf=%b data=%h exp 000 data=0",
               {out_v, stall, ovf_err}, out_data);
    end
    rst_n = 1'b1;
    tick();
    out_rdy = 1'b1;
    push_word(W'(32'h77));
    n_checks++;
    if (out_v !== 1'b1 || out_data !== W'(32'h77)) begin
      n_fail++;
      $display("FAIL rstmid_after: v=%b data=%h exp v=1 data=77", out_v, out_data);
    end
    tick();
    n_checks++;
    if (out_v !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_empty: v=%b exp 0", out_v);
    end
  endtask

`ifdef MVAU_OUT_LAST_EN
  task automatic test_out_last();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_rdy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      push_word(W'(k));
      n_checks++;
      if (out_v !== 1'b1 || out_data !== W'(k) || out_last !== (k % 4 == 0)) begin
        n_fail++;
        $display("FAIL last_stream[%0d]: v=%b data=%h last=%b exp v=1 data=%h last=%b",
                 k, out_v, out_data, out_last, W'(k), (k % 4 == 0));
      end
      tick();
    end
    push_word(W'(32'h41));
    tick();
    push_word(W'(32'h42));
    tick();
    out_rdy = 1'b0;
    push_word(W'(32'h43));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (out_v !== 1'b0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL last_reset: v=%b last=%b exp 0 0", out_v, out_last);
    end
    out_rdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      push_word(W'(32'h50 + k));
      n_checks++;
      if (out_v !== 1'b1 || out_last !== (k == 4)) begin
        n_fail++;
        $display("FAIL last_restart[%0d]: v=%b last=%b exp v=1 last=%b", k, out_v, out_last, (k == 4));
      end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_push();
    test_backpressure();
    test_full_simultaneous();
    test_overflow();
    test_reset_mid();
`ifdef MVAU_OUT_LAST_EN
    test_out_last();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
